// File: rtl/log_serializer_if.sv
// rtl/log_serializer_if.sv - channel-side and log-side bundle for the log serializer
//
// Purpose: collects the per-channel sample inputs and the serialized log
//          outputs of log_serializer into one bundle.
// Signals:
//   chan_dv_in     [N_LOG]          per-channel sample-valid strobe
//   chan_data_in   [N_LOG*W_LDATA]  per-channel samples, channel k at [k*W_LDATA +: W_LDATA]
//   log_mask_in    [N_LOG]          channel enable mask, 1 = logged
//   log_dv_out                      serialized sample valid
//   log_chan_out   [W_LCHAN]        channel index of the emitted sample
//   log_data_out   [W_LDATA]        emitted sample
//   ovf_count_out  [16]             saturating count of overwritten samples
// Modports: master = sample source / log sink, slave = serializer.
interface log_serializer_if #(
  parameter int N_LOG   = 8,
  parameter int W_LCHAN = 5,
  parameter int W_LDATA = 18
);
  logic [N_LOG-1:0]         chan_dv_in;
  logic [N_LOG*W_LDATA-1:0] chan_data_in;
  logic [N_LOG-1:0]         log_mask_in;
  logic                     log_dv_out;
  logic [W_LCHAN-1:0]       log_chan_out;
  logic [W_LDATA-1:0]       log_data_out;
  logic [15:0]              ovf_count_out;

  modport master (
    output chan_dv_in, chan_data_in, log_mask_in,
    input  log_dv_out, log_chan_out, log_data_out, ovf_count_out
  );

  modport slave (
    input  chan_dv_in, chan_data_in, log_mask_in,
    output log_dv_out, log_chan_out, log_data_out, ovf_count_out
  );
endinterface

// File: rtl/log_serializer.sv
// rtl/log_serializer.sv - round-robin serializer of N_LOG log channels onto one stream
//
// Purpose: each channel owns a holding register and a pending flag. A
//          round-robin arbiter picks one pending, enabled channel per cycle
//          and emits its held sample on registered outputs. A new sample on a
//          channel that is still pending overwrites it (latest wins).
// Ports:
//   pid_clk_in  sole clock, rising edge
//   rst_in      asynchronous active-high reset
//   bus         log_serializer_if.slave (strobes/data/mask in, log stream out)
// Configuration:
//   LOG_SERIALIZER_OVF_CNT_EN  defined: 16-bit saturating overwrite counter
//                              undefined: ovf_count_out tied to 0
module log_serializer #(
  parameter int N_LOG   = 8,
  parameter int W_LCHAN = 5,
  parameter int W_LDATA = 18
) (
  input  logic              pid_clk_in,
  input  logic              rst_in,
  log_serializer_if.slave   bus
);

  logic [W_LDATA-1:0] r_hold [N_LOG];
  logic [N_LOG-1:0]   r_pend;
  logic [W_LCHAN-1:0] r_rr_ptr;
  logic               r_dv;
  logic [W_LCHAN-1:0] r_chan;
  logic [W_LDATA-1:0] r_data;

  logic [N_LOG-1:0]   w_elig;
  logic               w_hi_vld;
  logic [W_LCHAN-1:0] w_hi_idx;
  logic               w_lo_vld;
  logic [W_LCHAN-1:0] w_lo_idx;
  logic               w_gnt_vld;
  logic [W_LCHAN-1:0] w_gnt_idx;
  logic [N_LOG-1:0]   w_gnt_oh;
  logic [W_LDATA-1:0] w_gnt_data;
  logic [W_LCHAN-1:0] w_rr_next;
  logic [N_LOG-1:0]   w_accept;

  assign w_elig   = r_pend & bus.log_mask_in;
  assign w_accept = bus.chan_dv_in & bus.log_mask_in;

  // Scan from the top down so the lowest qualifying index wins in each half:
  // "hi" covers indices at or above the pointer, "lo" covers all of them and
  // is only used when nothing at or above the pointer qualifies (wrap-around).
  always_comb begin
    w_hi_vld = 1'b0;
    w_hi_idx = '0;
    w_lo_vld = 1'b0;
    w_lo_idx = '0;
    for (int i = N_LOG - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_lo_vld = 1'b1;
        w_lo_idx = W_LCHAN'(i);
        if (W_LCHAN'(i) >= r_rr_ptr) begin
          w_hi_vld = 1'b1;
          w_hi_idx = W_LCHAN'(i);
        end
      end
    end
  end

  assign w_gnt_vld = w_hi_vld | w_lo_vld;
  assign w_gnt_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
  assign w_rr_next = (w_gnt_idx == W_LCHAN'(N_LOG - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    w_gnt_oh   = '0;
    w_gnt_data = '0;
    for (int k = 0; k < N_LOG; k++) begin
      if (w_gnt_vld && (w_gnt_idx == W_LCHAN'(k))) begin
        w_gnt_oh[k] = 1'b1;
        w_gnt_data  = r_hold[k];
      end
    end
  end

  // Channel state. A new sample always takes priority over the grant clear,
  // so a sample arriving in the grant cycle stays pending while the output
  // carries the previous hold value. Dropping the mask discards the pending
  // sample but keeps the hold register.
  always_ff @(posedge pid_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pend <= '0;
      for (int k = 0; k < N_LOG; k++) r_hold[k] <= '0;
    end else begin
      for (int k = 0; k < N_LOG; k++) begin
        if (w_accept[k]) r_hold[k] <= bus.chan_data_in[k*W_LDATA +: W_LDATA];
        if (!bus.log_mask_in[k])  r_pend[k] <= 1'b0;
        else if (w_accept[k])     r_pend[k] <= 1'b1;
        else if (w_gnt_oh[k])     r_pend[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge pid_clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_dv     <= 1'b0;
      r_chan   <= '0;
      r_data   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_dv <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_chan   <= w_gnt_idx;
        r_data   <= w_gnt_data;
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  assign bus.log_dv_out   = r_dv;
  assign bus.log_chan_out = r_chan;
  assign bus.log_data_out = r_data;

`ifdef LOG_SERIALIZER_OVF_CNT_EN
  logic [15:0]      r_ovf;
  logic [N_LOG-1:0] w_ovf_ev;
  logic [16:0]      w_ovf_sum;

  // An overwrite is an accepted sample landing on a still-pending channel
  // that is not being drained this cycle.
  assign w_ovf_ev = w_accept & r_pend & ~w_gnt_oh;

  always_comb begin
    w_ovf_sum = {1'b0, r_ovf};
    for (int k = 0; k < N_LOG; k++) w_ovf_sum = w_ovf_sum + 17'(w_ovf_ev[k]);
  end

  always_ff @(posedge pid_clk_in or posedge rst_in) begin
    if (rst_in)            r_ovf <= '0;
    else if (w_ovf_sum[16]) r_ovf <= 16'hFFFF;
    else                   r_ovf <= w_ovf_sum[15:0];
  end

  assign bus.ovf_count_out = r_ovf;
`else
  assign bus.ovf_count_out = '0;
`endif

endmodule

// File: tb/tb_log_serializer.sv
// tb/tb_log_serializer.sv - directed self-checking bench for log_serializer
module tb_log_serializer;
  localparam int N_LOG   = 8;
  localparam int W_LCHAN = 5;
  localparam int W_LDATA = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  log_serializer_if #(.N_LOG(N_LOG), .W_LCHAN(W_LCHAN), .W_LDATA(W_LDATA)) bus ();

  log_serializer #(.N_LOG(N_LOG), .W_LCHAN(W_LCHAN), .W_LDATA(W_LDATA)) u_dut (
    .pid_clk_in (clk),
    .rst_in     (rst),
    .bus        (bus)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [W_LDATA-1:0] v);
    bus.chan_data_in[k*W_LDATA +: W_LDATA] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.chan_dv_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int ch, input logic [W_LDATA-1:0] d);
    check_vec({tag, "_dv"},   32'(bus.log_dv_out),   32'd1);
    check_vec({tag, "_chan"}, 32'(bus.log_chan_out), 32'(ch));
    check_vec({tag, "_data"}, 32'(bus.log_data_out), 32'(d));
  endtask

  logic [15:0] exp_ovf;

  initial begin
    bus.chan_dv_in   = '0;
    bus.chan_data_in = '0;
    bus.log_mask_in  = '1;
    #2;
    check_vec("rst_dv",   32'(bus.log_dv_out),    32'd0);
    check_vec("rst_chan", 32'(bus.log_chan_out),  32'd0);
    check_vec("rst_data", 32'(bus.log_data_out),  32'd0);
    check_vec("rst_ovf",  32'(bus.ovf_count_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // single sample on channel 3, two cycles of latency, one-cycle pulse
    set_data(3, 18'h2ABCD);
    bus.chan_dv_in[3] = 1'b1;
    tick();
    bus.chan_dv_in = '0;
    check_vec("single_early", 32'(bus.log_dv_out), 32'd0);
    tick();
    expect_out("single", 3, 18'h2ABCD);
    tick();
    check_vec("single_dv_off", 32'(bus.log_dv_out),   32'd0);
    check_vec("single_hold_c", 32'(bus.log_chan_out), 32'd3);
    check_vec("single_hold_d", 32'(bus.log_data_out), 32'h2ABCD);

    // round-robin: all eight at once drain 0..7, then 0 and 2 drain 0 then 2
    do_reset();
    for (int k = 0; k < N_LOG; k++) set_data(k, W_LDATA'(k));
    bus.chan_dv_in = '1;
    tick();
    bus.chan_dv_in = '0;
    for (int i = 0; i < N_LOG; i++) begin
      tick();
      expect_out($sformatf("rr%0d", i), i, W_LDATA'(i));
    end
    set_data(0, 18'h00AA0);
    set_data(2, 18'h00AA2);
    bus.chan_dv_in = 8'b0000_0101;
    tick();
    bus.chan_dv_in = '0;
    tick();
    expect_out("rr_pair0", 0, 18'h00AA0);
    tick();
    expect_out("rr_pair2", 2, 18'h00AA2);
    tick();
    check_vec("rr_idle", 32'(bus.log_dv_out), 32'd0);

    // wrap: grant 5 leaves pointer at 6, so 7 beats 1
    do_reset();
    set_data(5, 18'h00055);
    bus.chan_dv_in = 8'b0010_0000;
    tick();
    bus.chan_dv_in = '0;
    tick();
    expect_out("wrap5", 5, 18'h00055);
    set_data(1, 18'h10001);
    set_data(7, 18'h10007);
    bus.chan_dv_in = 8'b1000_0010;
    tick();
    bus.chan_dv_in = '0;
    tick();
    expect_out("wrap7", 7, 18'h10007);
    tick();
    expect_out("wrap1", 1, 18'h10001);

    // overwrite: channel 7 restrobed while still pending
    do_reset();
    for (int k = 0; k < N_LOG; k++) set_data(k, W_LDATA'(k));
    bus.chan_dv_in = '1;
    tick();
    bus.chan_dv_in = '0;
    for (int i = 0; i < N_LOG; i++) begin
      if (i == 2) begin
        set_data(7, 18'h3FFFF);
        bus.chan_dv_in[7] = 1'b1;
      end
      tick();
      bus.chan_dv_in = '0;
      expect_out($sformatf("ovw%0d", i), i, (i == 7) ? 18'h3FFFF : W_LDATA'(i));
    end
`ifdef LOG_SERIALIZER_OVF_CNT_EN
    exp_ovf = 16'd1;
`else
    exp_ovf = 16'd0;
`endif
    check_vec("ovw_count", 32'(bus.ovf_count_out), 32'(exp_ovf));

    // mask drop discards the pending sample on channel 4
    do_reset();
    set_data(4, 18'h00444);
    bus.chan_dv_in[4] = 1'b1;
    tick();
    bus.chan_dv_in = '0;
    bus.log_mask_in[4] = 1'b0;
    tick();
    check_vec("mask_drop0", 32'(bus.log_dv_out), 32'd0);
    bus.log_mask_in = '1;
    tick();
    check_vec("mask_drop1", 32'(bus.log_dv_out), 32'd0);

    // reset pulse mid-burst clears outputs at once; strobes during reset ignored
    bus.chan_dv_in = '1;
    tick();
    bus.chan_dv_in = '0;
    tick();
    tick();
    expect_out("burst1", 1, 18'h00001);
    rst = 1'b1;
    bus.chan_dv_in = '1;
    #1;
    check_vec("mid_rst_dv",   32'(bus.log_dv_out),   32'd0);
    check_vec("mid_rst_chan", 32'(bus.log_chan_out), 32'd0);
    check_vec("mid_rst_data", 32'(bus.log_data_out), 32'd0);
    tick();
    rst = 1'b0;
    bus.chan_dv_in = '0;
    tick();
    check_vec("post_rst0", 32'(bus.log_dv_out), 32'd0);
    tick();
    check_vec("post_rst1", 32'(bus.log_dv_out), 32'd0);

    // saturation: all channels strobe every cycle, 7 overwrites per cycle
    do_reset();
    bus.chan_dv_in = '1;
    for (int n = 0; n < 10; n++) tick();
`ifdef LOG_SERIALIZER_OVF_CNT_EN
    exp_ovf = 16'd63;
`else
    exp_ovf = 16'd0;
`endif
    check_vec("ovf_63", 32'(bus.ovf_count_out), 32'(exp_ovf));
    for (int n = 0; n < 10090; n++) tick();
`ifdef LOG_SERIALIZER_OVF_CNT_EN
    exp_ovf = 16'hFFFF;
`else
    exp_ovf = 16'd0;
`endif
    check_vec("ovf_sat", 32'(bus.ovf_count_out), 32'(exp_ovf));
    tick();
    check_vec("ovf_sat_hold", 32'(bus.ovf_count_out), 32'(exp_ovf));
    bus.chan_dv_in = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
